// File: rtl/slip_multi_ch_dumper.sv
// rtl/slip_multi_ch_dumper.sv - snapshot NUM_CH channels on a strobe and serialise them as one SLIP frame
//
// Purpose:
//   On an eligible sample strobe, capture all channels and feed them to slip_tx one byte at a
//   time. Bytes go LSB first, channel 0 first. Strobes are decimated by DECIM. Eligible strobes
//   that arrive while a frame is in flight are counted in a saturating drop counter.
//   Optional macro FRAME_SEQ_EN prepends an 8-bit frame sequence number to every frame.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_sample_vld      1-cycle strobe, i_samples valid
//   i_samples         channel k at [k*CH_WIDTH +: CH_WIDTH]
//   o_slip_start      1-cycle pulse, open frame
//   o_slip_end        1-cycle pulse, close frame
//   o_slip_dv         1-cycle pulse, o_slip_byte valid
//   o_slip_byte       payload byte
//   i_slip_byte_done  1-cycle pulse from slip_tx, previous item accepted
//   o_busy            high whenever a frame is in flight
//   o_drop_cnt        saturating count of eligible strobes dropped while busy

module slip_multi_ch_dumper #(
    parameter int NUM_CH   = 3,
    parameter int CH_WIDTH = 16,
    parameter int DECIM    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_sample_vld,
    input  logic [NUM_CH*CH_WIDTH-1:0] i_samples,
    output logic                       o_slip_start,
    output logic                       o_slip_end,
    output logic                       o_slip_dv,
    output logic [7:0]                 o_slip_byte,
    input  logic                       i_slip_byte_done,
    output logic                       o_busy,
    output logic [15:0]                o_drop_cnt
);

    localparam int BPC       = (CH_WIDTH + 7) / 8;
    localparam int PAY_BYTES = NUM_CH * BPC;
`ifdef FRAME_SEQ_EN
    localparam int NBYTES    = PAY_BYTES + 1;
`else
    localparam int NBYTES    = PAY_BYTES;
`endif
    localparam int IDX_W     = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] NBYTES_IDX = IDX_W'(NBYTES);
    localparam logic [15:0]      DCNT_MAX   = 16'(DECIM - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        END_WAIT = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PAY_BYTES*8-1:0] snap;
    logic [PAY_BYTES*8-1:0] snap_in;
    logic [IDX_W-1:0]       idx;
    logic [15:0]            dcnt;
    logic                   eligible;
    logic                   more_bytes;
    logic                   start_next;
    logic                   dv_next;
    logic                   end_next;
    logic [7:0]             byte_next;
    logic [7:0]             cur_byte;

    // Each channel occupies a whole number of bytes; unused top bits stay zero.
    always_comb begin
        snap_in = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            snap_in[k*BPC*8 +: CH_WIDTH] = i_samples[k*CH_WIDTH +: CH_WIDTH];
        end
    end

`ifdef FRAME_SEQ_EN
    logic [7:0]       seq;
    logic [IDX_W-1:0] pay_idx;

    // Byte 0 of the frame is the sequence number, so payload indices are shifted by one.
    assign pay_idx  = idx - IDX_W'(1);
    assign cur_byte = (idx == '0) ? seq : 8'(snap >> {pay_idx, 3'b000});
`else
    assign cur_byte = 8'(snap >> {idx, 3'b000});
`endif

    assign eligible   = i_sample_vld && (dcnt == '0);
    assign more_bytes = (idx < NBYTES_IDX);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            snap         <= '0;
            idx          <= '0;
            dcnt         <= '0;
            o_drop_cnt   <= '0;
            o_slip_start <= 1'b0;
            o_slip_end   <= 1'b0;
            o_slip_dv    <= 1'b0;
            o_slip_byte  <= '0;
`ifdef FRAME_SEQ_EN
            seq          <= '0;
`endif
        end else begin
            state        <= state_next;
            o_slip_start <= start_next;
            o_slip_end   <= end_next;
            o_slip_dv    <= dv_next;
            o_slip_byte  <= byte_next;

            if (i_sample_vld) begin
                dcnt <= (dcnt == DCNT_MAX) ? '0 : dcnt + 16'd1;
            end

            if (start_next) begin
                snap <= snap_in;
                idx  <= '0;
            end else if (dv_next) begin
                idx  <= idx + IDX_W'(1);
            end

            // Any state other than IDLE is busy, including the END_WAIT cycle where done arrives.
            if (eligible && (state != IDLE) && (o_drop_cnt != 16'hFFFF)) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end

`ifdef FRAME_SEQ_EN
            if (end_next) begin
                seq <= seq + 8'd1;
            end
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (eligible) state_next = SEND;
            SEND:     if (i_slip_byte_done && !more_bytes) state_next = END_WAIT;
            END_WAIT: if (i_slip_byte_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Output logic: values the pulse registers take on the next edge
    always_comb begin
        start_next = 1'b0;
        dv_next    = 1'b0;
        end_next   = 1'b0;
        byte_next  = 8'h00;
        o_busy     = (state != IDLE);
        case (state)
            IDLE: begin
                start_next = eligible;
            end
            SEND: begin
                if (i_slip_byte_done) begin
                    if (more_bytes) begin
                        dv_next   = 1'b1;
                        byte_next = cur_byte;
                    end else begin
                        end_next  = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule
